// File: rtl/wb_result_buffer.sv
// In-order result queue between a multi-cycle execution unit and the writeback arbiter.
// Holds completed {id, rd} results and presents the oldest until the arbiter acks it.
module wb_result_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ID_WIDTH-1:0]          in_id,
    input  logic [DATA_WIDTH-1:0]        in_rd,
    output logic                         done,
    output logic [ID_WIDTH-1:0]          id,
    output logic [DATA_WIDTH-1:0]        rd,
    input  logic                         ack,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = ID_WIDTH + DATA_WIDTH;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count_q != FULL_CNT);
    assign done      = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = ack & done;
    assign id        = mem_q[rd_ptr_q][EW-1:DATA_WIDTH];
    assign rd        = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign occupancy = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rst || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Storage is deliberately not reset; contents are only observed while done=1.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem_q[wr_ptr_q] <= {in_id, in_rd};
    end

`ifndef SYNTHESIS
    logic                  chk_hold_q;
    logic [ID_WIDTH-1:0]   chk_id_q;
    logic [DATA_WIDTH-1:0] chk_rd_q;

    always_ff @(posedge clk) begin
        chk_hold_q <= done && !ack && !rst && !flush;
        chk_id_q   <= id;
        chk_rd_q   <= rd;
        if (!rst) begin
            assert (count_q <= FULL_CNT) else $error("count exceeds DEPTH");
            assert (!(push && count_q == FULL_CNT)) else $error("push while full");
            if (chk_hold_q) begin
                assert (done && id == chk_id_q && rd == chk_rd_q)
                    else $error("head changed while waiting for ack");
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_result_buffer.sv
// Bench for wb_result_buffer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the result buffer.
module tb_wb_result_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 3;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, ack;
    logic          in_ready, done;
    logic [IW-1:0] in_id, id;
    logic [DW-1:0] in_rd, rd;
    logic [2:0]    occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] rd;
    } ent_t;
    ent_t model[$];

    wb_result_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_id     (in_id),
        .in_rd     (in_rd),
        .done      (done),
        .id        (id),
        .rd        (rd),
        .ack       (ack),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, clock once, then apply the cycle's effect to the model.
    task automatic cycle();
        int n;
        bit pu, po;
        ent_t e;
        n = model.size();
        check("in_ready", 64'(in_ready), 64'(n < DEPTH));
        check("done", 64'(done), 64'(n != 0));
        check("occupancy", 64'(occupancy), 64'(n));
        if (n != 0) begin
            check("id", 64'(id), 64'(model[0].id));
            check("rd", 64'(rd), 64'(model[0].rd));
        end
        @(posedge clk);
        pu = in_valid && (n < DEPTH);
        po = ack && (n > 0);
        if (rst || flush) begin
            model.delete();
        end else begin
            if (po) void'(model.pop_front());
            if (pu) begin
                e.id = in_id;
                e.rd = in_rd;
                model.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [IW-1:0] pid, input logic [DW-1:0] prd);
        in_valid = 1'b1;
        in_id    = pid;
        in_rd    = prd;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        ack = 1'b1;
        idle(DEPTH + 1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; ack = 1'b0;
        in_id = '0; in_rd = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model.delete();

        // Reset then idle, with a stray ack on an empty buffer
        idle(1);
        ack = 1'b1;
        idle(2);
        ack = 1'b0;

        // Single result held for 10 cycles, then acked
        push(3'd5, 32'hDEADBEEF);
        idle(10);
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        idle(1);

        // Fill, dropped fifth push, partial drain, wrap
        for (int i = 0; i < 4; i++) push(IW'(i), 32'h1000 + 32'(i));
        push(3'd4, 32'hBAD0_0004);
        ack = 1'b1;
        idle(2);
        ack = 1'b0;
        push(3'd4, 32'h1004);
        push(3'd5, 32'h1005);
        drain();

        // Steady push+pop at count=2
        push(3'd0, 32'h2000);
        push(3'd1, 32'h2001);
        ack = 1'b1;
        for (int i = 2; i < 22; i++) push(IW'(i % 8), 32'h2000 + 32'(i));
        drain();

        // Flush with concurrent push
        for (int i = 0; i < 3; i++) push(IW'(i), 32'h3000 + 32'(i));
        flush = 1'b1;
        push(3'd6, 32'h3006);
        flush = 1'b0;
        idle(2);

        // Reset mid-operation with ack high
        for (int i = 0; i < 4; i++) push(IW'(i), 32'h4000 + 32'(i));
        rst = 1'b1;
        ack = 1'b1;
        idle(1);
        rst = 1'b0;
        ack = 1'b0;
        idle(1);
        push(3'd2, 32'h4002);
        idle(1);
        drain();

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            ack      = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            in_id    = IW'($urandom);
            in_rd    = $urandom;
            cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_result_buffer.md
Name: wb_result_buffer

Overview:
- Per-unit result queue between a multi-cycle execution unit and the writeback arbiter.
- Accepts completed results (instruction id plus rd data) from the unit.
- Holds results in order and presents the oldest on the unit writeback done/id/rd signals until the arbiter acks it.
- Decouples unit completion from port arbitration so units need not stall when their writeback group is busy.

Parameters:
- DEPTH, 4, number of result entries; integer >= 2, need not be a power of two.
- DATA_WIDTH, 32, width of rd result data.
- ID_WIDTH, 3, width of instruction id.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous discard of all held entries.
- in_valid  input  1  unit presents a completed result this cycle.
- in_ready  output  1  buffer can accept a result this cycle.
- in_id  input  ID_WIDTH  instruction id of incoming result.
- in_rd  input  DATA_WIDTH  result data of incoming result.
- done  output  1  head entry valid (to writeback arbiter).
- id  output  ID_WIDTH  instruction id of head entry.
- rd  output  DATA_WIDTH  result data of head entry.
- ack  input  1  arbiter consumed head entry this cycle.
- occupancy  output  $clog2(DEPTH+1)  number of held entries.

Behaviour:
- Storage: circular array of DEPTH entries {id, rd}. Write pointer, read pointer and count are registers.
  - Pointers increment modulo DEPTH, wrapping from DEPTH-1 to 0. No power-of-two reliance.
- Push = in_valid & in_ready. Pop = ack & done.
- in_ready = (count != DEPTH), combinational from count only. Never depends on ack. No push-through when full.
- done = (count != 0). id/rd = entry at read pointer, combinational read.
- Latency: a result pushed in cycle N gives done=1 with that id/rd in cycle N+1 at the earliest. There is no same-cycle bypass.
- Ack semantics:
  - ack while done=0 is ignored.
  - ack is sampled at the clock edge. The head advances the following cycle.
  - done/id/rd must stay stable while done=1 and ack=0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, both pointers advance. Legal at any count from 1 to DEPTH-1.
  - At count=DEPTH, push is blocked, so pop alone applies.
- in_valid while in_ready=0 is dropped. The unit must hold the result and retry.
- Order: strictly FIFO. id and rd are returned exactly as pushed.
- flush: count, write pointer and read pointer go to 0 next cycle.
  - A push in the same cycle as flush is discarded.
  - A pop in the same cycle as flush is irrelevant.
  - Flush takes priority over push and pop.
- Reset: same effect as flush; rst has priority over flush.
  - Reset values: count=0, pointers=0, so done=0, in_ready=1, occupancy=0.
  - id/rd are undefined while done=0; storage is not reset.
- occupancy = count, registered.
- Reset mid-operation: all held results are lost. The buffer is empty the cycle after rst is released.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No push while full.
  - id/rd stable while done & ~ack.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> done=0, in_ready=1, occupancy=0. ack=1 with no push leaves occupancy=0.
- Single result: push id=5, rd=0xDEADBEEF in cycle N, ack held 0 -> done=1 from N+1 with id=5, rd=0xDEADBEEF, stable for 10 cycles. ack=1 at N+11 -> done=0 at N+12.
- Fill and wrap (DEPTH=4):
  - push ids 0..3 with ack=0 -> occupancy=4, in_ready=0. A fifth push of id=4 is dropped.
  - Ack twice, then push ids 4 and 5 -> pops return 0,1,2,3,4,5 in order. Pointer wraps past 3 correctly.
- Simultaneous push/pop: steady state with count=2, push and ack every cycle for 20 cycles (ids 0..7 repeating) -> occupancy stays 2 and output ids follow push order delayed by 2 entries.
- Flush with concurrent push: count=3, flush=1 and in_valid=1 (id=6) in the same cycle -> next cycle done=0, occupancy=0. id=6 never appears on the output.
- Reset mid-operation: count=4, assert rst for 1 cycle with ack=1 -> after release done=0, in_ready=1, occupancy=0. A subsequent push of id=2 appears alone.
